restoring_divider: RTL and testbench

Multi-cycle unsigned integer divider. Computes `quotient = dividend / divisor` and `remainder = dividend % divisor` on `data_t` operands using restoring shift-subtract, one quotient bit per clock. Each trial subtraction reuses the existing `ripplecarry_adder`, so this block is the inverse-arithmetic counterpart of the adder. It sits beside the adder as a valid/ready arithmetic unit for the SoC datapath.

---
 rtl/soc_pkg.sv | 19 +
 rtl/ripplecarry_adder.sv | 26 ++
 rtl/restoring_divider.sv | 179 +++++++++++++++++
 tb/tb_restoring_divider.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared SoC datapath types: operand width, operand type, divider FSM states
// and the step counter type used by the restoring divider.
package soc_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [$clog2(DATA_WIDTH+1)-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter value during the final restoring step of a division.
    localparam count_t LAST_STEP = count_t'(DATA_WIDTH - 1);

endpackage

// File: rtl/ripplecarry_adder.sv
// Plain ripple-carry adder: o_sum = i_a + i_b + i_carry_in, with carry out.
// The divider reuses it as a subtractor via the ~(~a + b) identity.
module ripplecarry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_carry_in;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic w_prop;
        assign w_prop       = i_a[g] ^ i_b[g];
        assign o_sum[g]     = w_prop ^ w_carry[g];
        assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & w_prop);
    end

    assign o_carry_out = w_carry[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes.
// One quotient bit per clock; trial subtraction through ripplecarry_adder.
module restoring_divider
    import soc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t dividend,
    input  data_t divisor,
    output logic  out_valid,
    input  logic  out_ready,
    output data_t quotient,
    output data_t remainder,
    output logic  div_by_zero
);

    div_state_t r_state;
    div_state_t w_next_state;

    data_t  r_q;
    data_t  r_r;
    data_t  r_d;
    count_t r_count;

    data_t  r_quotient;
    data_t  r_remainder;
    logic   r_div_by_zero;
    logic   r_out_valid;

    logic   w_in_ready;
    logic   w_accept;
    logic   w_handoff;
    logic   w_last_step;

    logic   w_msb;
    data_t  w_t;
    data_t  w_sum;
    logic   w_lt;
    data_t  w_diff;
    logic   w_take;
    data_t  w_r_next;
    data_t  w_q_next;

    // One restoring step: shift {R,Q} left and trial-subtract D from the new R.
    assign w_msb = r_r[DATA_WIDTH-1];
    assign w_t   = {r_r[DATA_WIDTH-2:0], r_q[DATA_WIDTH-1]};

    ripplecarry_adder #(
        .WIDTH (DATA_WIDTH)
    ) u_trial_sub (
        .i_a         (~w_t),
        .i_b         (r_d),
        .i_carry_in  (1'b0),
        .o_sum       (w_sum),
        .o_carry_out (w_lt)
    );

    // A set msb means the shifted remainder exceeds 2^N > D, so subtract regardless.
    assign w_diff   = ~w_sum;
    assign w_take   = w_msb | ~w_lt;
    assign w_r_next = w_take ? w_diff : w_t;
    assign w_q_next = {r_q[DATA_WIDTH-2:0], w_take};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (divisor == {DATA_WIDTH{1'b0}}) ? DONE : CALC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CALC: begin
                w_next_state = w_last_step ? DONE : CALC;
            end
            DONE: begin
                w_next_state = w_handoff ? IDLE : DONE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Handshake and control decode from the current state.
    always_comb begin
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_handoff   = 1'b0;
        w_last_step = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = ~rst;
                w_accept   = in_valid;
            end
            CALC: begin
                w_last_step = (r_count == LAST_STEP);
            end
            DONE: begin
                w_handoff = r_out_valid & out_ready;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // Working registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q           <= {DATA_WIDTH{1'b0}};
            r_r           <= {DATA_WIDTH{1'b0}};
            r_d           <= {DATA_WIDTH{1'b0}};
            r_count       <= count_t'(0);
            r_quotient    <= {DATA_WIDTH{1'b0}};
            r_remainder   <= {DATA_WIDTH{1'b0}};
            r_div_by_zero <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q     <= dividend;
                        r_d     <= divisor;
                        r_r     <= {DATA_WIDTH{1'b0}};
                        r_count <= count_t'(0);
                        if (divisor == {DATA_WIDTH{1'b0}}) begin
                            r_quotient    <= {DATA_WIDTH{1'b1}};
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_q     <= w_q_next;
                    r_r     <= w_r_next;
                    r_count <= r_count + count_t'(1);
                    if (w_last_step) begin
                        r_quotient    <= w_q_next;
                        r_remainder   <= w_r_next;
                        r_div_by_zero <= 1'b0;
                        r_out_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    // Divide-by-zero enters DONE straight from IDLE; valid follows one edge later.
                    if (w_handoff) begin
                        r_out_valid <= 1'b0;
                    end else if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized self-checking bench for restoring_divider.
module tb_restoring_divider;
    import soc_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  in_valid = 1'b0;
    logic  out_ready = 1'b0;
    data_t dividend = 8'd0;
    data_t divisor = 8'd0;
    logic  in_ready;
    logic  out_valid;
    data_t quotient;
    data_t remainder;
    logic  div_by_zero;

    int checks = 0;
    int failures = 0;

    restoring_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Wait for in_ready, present operands for one accept edge, then scramble them.
    task automatic issue(input data_t a, input data_t b);
        int guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Count edges after accept until out_valid; -1 when the bound expires.
    task automatic wait_out(input bit noise, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            @(posedge clk); #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        end
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: q=%0d r=%0d dbz=%b expected 0 0 0", quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int cyc;
        issue(8'd200, 8'd7);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_drop: in_ready=%b expected 0", in_ready);
        end
        wait_out(1'b0, cyc);
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected 8", cyc);
        end
        checks++;
        if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b expected 28 4 0", quotient, remainder, div_by_zero);
        end
        handoff();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_handoff: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        issue(8'd100, 8'd0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL dz_early_valid: out_valid=%b expected 0", out_valid);
        end
        wait_out(1'b0, cyc);
        checks++;
        if (cyc !== 1) begin
            failures++;
            $display("FAIL dz_latency: got %0d expected 1", cyc);
        end
        checks++;
        if (quotient !== 8'd255 || remainder !== 8'd100 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dz_result: q=%0d r=%0d dbz=%b expected 255 100 1", quotient, remainder, div_by_zero);
        end
        handoff();
    endtask

    task automatic test_boundary();
        data_t va [4] = '{8'd255, 8'd5, 8'd255, 8'd128};
        data_t vb [4] = '{8'd1,   8'd9, 8'd255, 8'd2};
        data_t eq [4] = '{8'd255, 8'd0, 8'd1,   8'd64};
        data_t er [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i]);
            wait_out(1'b0, cyc);
            checks++;
            if (cyc !== 8 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL boundary_%0d_div_%0d: lat=%0d q=%0d r=%0d dbz=%b expected 8 %0d %0d 0",
                         va[i], vb[i], cyc, quotient, remainder, div_by_zero, eq[i], er[i]);
            end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        issue(8'd77, 8'd5);
        wait_out(1'b0, cyc);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd15 || remainder !== 8'd2) begin
                failures++;
                $display("FAIL bp_hold_%0d: valid=%b ready=%b q=%0d r=%0d expected 1 0 15 2",
                         i, out_valid, in_ready, quotient, remainder);
            end
            @(posedge clk); #1;
        end
        handoff();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen = 1'b0;
        issue(8'd200, 8'd7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || quotient !== 8'd0) begin
            failures++;
            $display("FAIL midrst_state: valid=%b ready=%b q=%0d expected 0 0 0", out_valid, in_ready, quotient);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_valid: saw out_valid=%b expected 0", seen);
        end
        issue(8'd9, 8'd3);
        wait_out(1'b0, cyc);
        checks++;
        if (cyc !== 8 || quotient !== 8'd3 || remainder !== 8'd0) begin
            failures++;
            $display("FAIL midrst_next_op: lat=%0d q=%0d r=%0d expected 8 3 0", cyc, quotient, remainder);
        end
        handoff();
    endtask

    task automatic test_random();
        int cyc;
        int n_results = 0;
        data_t a, b, exp_q, exp_r;
        logic exp_z;
        for (int n = 0; n < 500; n++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            exp_z = (b == 8'd0);
            exp_q = exp_z ? 8'd255 : data_t'(a / b);
            exp_r = exp_z ? a : data_t'(a % b);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            issue(a, b);
            wait_out(1'b1, cyc);
            if (cyc > 0) n_results++;
            checks++;
            if (cyc < 0 || quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_z) begin
                failures++;
                $display("FAIL rand_%0d_%0d_div_%0d: lat=%0d q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                         n, a, b, cyc, quotient, remainder, div_by_zero, exp_q, exp_r, exp_z);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            handoff();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rand_dup_%0d: out_valid=%b after handoff expected 0", n, out_valid);
            end
        end
        checks++;
        if (n_results !== 500) begin
            failures++;
            $display("FAIL rand_result_count: got %0d expected 500", n_results);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
